// File: rtl/fp_div_pkg.sv
// rtl/fp_div_pkg.sv - shared types and constants for the floating-point divider
package fp_div_pkg;

  localparam int DEF_EXP_W = 5;
  localparam int DEF_MAN_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIVIDE = 2'd1,
    ST_NORM   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Special-value field constants; the exponent of inf/NaN is SPECIAL_EXP_BIT replicated
  localparam logic QNAN_SIGN       = 1'b0;
  localparam logic SPECIAL_EXP_BIT = 1'b1;
  localparam logic QNAN_MAN_MSB    = 1'b1;
  localparam logic INF_MAN_BIT     = 1'b0;

endpackage

// File: rtl/dff.sv
// rtl/dff.sv - enabled D flip-flop cell with asynchronous active-low reset to zero
module dff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Hold q unless enabled; reset clears asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fp_mant_div.sv
// rtl/fp_mant_div.sv - restoring mantissa divider, one quotient bit per step
module fp_mant_div #(
  parameter int MAN_W = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           step,
  input  logic [MAN_W:0] dividend,
  input  logic [MAN_W:0] divisor,
  output logic [MAN_W+2:0] quotient,
  output logic           sticky,
  output logic           last
);

  // Integer bit, MAN_W fraction bits, plus one bit each for normalise and guard
  localparam int ITER  = MAN_W + 3;
  localparam int CNT_W = $clog2(ITER + 1);
  // Remainder stays below twice the divisor, so one extra bit suffices
  localparam int REM_W = MAN_W + 2;

  logic [REM_W-1:0] rem;
  logic [REM_W-1:0] rem_sel;
  logic [REM_W-1:0] diff;
  logic [MAN_W:0]   dvs;
  logic [CNT_W-1:0] cnt;
  logic             ge;

  // Trial subtraction of the divisor from the running remainder
  always_comb begin
    diff    = rem - {1'b0, dvs};
    ge      = (rem >= {1'b0, dvs});
    rem_sel = ge ? diff : rem;
  end

  // Load operands, then shift in one quotient bit per step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem      <= '0;
      dvs      <= '0;
      quotient <= '0;
      cnt      <= '0;
    end else if (load) begin
      rem      <= {1'b0, dividend};
      dvs      <= divisor;
      quotient <= '0;
      cnt      <= '0;
    end else if (step) begin
      rem      <= {rem_sel[REM_W-2:0], 1'b0};
      quotient <= {quotient[ITER-2:0], ge};
      cnt      <= cnt + 1'b1;
    end
  end

  assign sticky = |rem;
  assign last   = (cnt == CNT_W'(ITER - 1));

endmodule

// File: rtl/fp_divider_n.sv
// rtl/fp_divider_n.sv - multi-cycle IEEE-style floating-point divider with flush-to-zero
module fp_divider_n
  import fp_div_pkg::*;
#(
  parameter int  EXP_W  = DEF_EXP_W,
  parameter int  MAN_W  = DEF_MAN_W,
  localparam int DATA_W = 1 + EXP_W + MAN_W
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic [DATA_W-1:0] input_a,
  input  logic [DATA_W-1:0] input_b,
  input  logic              start,
  input  logic              clear,
  output logic              busy,
  output logic              valid,
  output logic [DATA_W-1:0] result,
  output logic              div_by_zero,
  output logic              invalid
);

  localparam int ITER = MAN_W + 3;
  // Exponent math carries two extra bits: one for overflow headroom, one for sign
  localparam int SE_W = EXP_W + 2;
  localparam logic [SE_W-1:0] BIAS    = SE_W'((1 << (EXP_W - 1)) - 1);
  localparam logic [SE_W-1:0] EXP_MAX = SE_W'((1 << EXP_W) - 1);

  state_t state;
  state_t state_next;
  logic [1:0] state_q;

  logic accept;
  logic step;
  logic norm_fire;
  logic div_last;
  logic valid_next;
  logic [1:0] flags_d;
  logic [1:0] flags_q;
  logic flags_en;

  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              sign_a, sign_b, sign_q;
  logic [EXP_W-1:0]  exp_a, exp_b;
  logic [MAN_W-1:0]  man_a, man_b;
  logic zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;

  logic [ITER-1:0] quo;
  logic            rem_nz;

  logic            norm_shift;
  logic [MAN_W:0]  mant_n;
  logic            guard;
  logic            sticky_all;
  logic            round_up;
  logic [MAN_W+1:0] mant_r;
  logic            carry;
  logic [MAN_W-1:0] frac;
  logic [SE_W-1:0] e_raw;
  logic            ovf;
  logic            unf;

  logic [DATA_W-1:0] inf_word;
  logic [DATA_W-1:0] zero_word;
  logic [DATA_W-1:0] qnan_word;
  logic [DATA_W-1:0] res_n;
  logic              dbz_n;
  logic              inv_n;

  dff #(.W(2)) u_state_reg (
    .clk   (clk),
    .rst_n (reset_b),
    .en    (1'b1),
    .d     (state_next),
    .q     (state_q)
  );
  assign state = state_t'(state_q);

  // Next-state: DONE accepts start like IDLE; clear aborts only an in-flight op
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_next = ST_DIVIDE;
        end else if (clear) begin
          state_next = ST_IDLE;
        end
      end
      ST_DIVIDE: begin
        if (clear) begin
          state_next = ST_IDLE;
        end else if (div_last) begin
          state_next = ST_NORM;
        end
      end
      ST_NORM: begin
        state_next = clear ? ST_IDLE : ST_DONE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Control outputs decoded from the current state
  always_comb begin
    busy      = 1'b0;
    accept    = 1'b0;
    step      = 1'b0;
    norm_fire = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: accept = start;
      ST_DIVIDE: begin
        busy = 1'b1;
        step = ~clear;
      end
      ST_NORM: begin
        busy      = 1'b1;
        norm_fire = ~clear;
      end
      default: ;
    endcase
  end

  // Valid is sticky: set on completion, dropped by a new op or a clear
  always_comb begin
    valid_next = valid;
    if (norm_fire) begin
      valid_next = 1'b1;
    end else if (accept || clear) begin
      valid_next = 1'b0;
    end
  end

  dff #(.W(1)) u_valid_reg (
    .clk   (clk),
    .rst_n (reset_b),
    .en    (1'b1),
    .d     (valid_next),
    .q     (valid)
  );

  assign flags_en = accept | norm_fire;
  assign flags_d  = norm_fire ? {dbz_n, inv_n} : 2'b00;

  dff #(.W(2)) u_flags_reg (
    .clk   (clk),
    .rst_n (reset_b),
    .en    (flags_en),
    .d     (flags_d),
    .q     (flags_q)
  );
  assign {div_by_zero, invalid} = flags_q;

  // Capture operands on accepted start and the rounded result on completion
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      op_a   <= '0;
      op_b   <= '0;
      result <= '0;
    end else begin
      if (accept) begin
        op_a <= input_a;
        op_b <= input_b;
      end
      if (norm_fire) begin
        result <= res_n;
      end
    end
  end

  // Hidden bit is always 1 here; zero/special operands are overridden at the end
  fp_mant_div #(.MAN_W(MAN_W)) u_mant_div (
    .clk      (clk),
    .rst_n    (reset_b),
    .load     (accept),
    .step     (step),
    .dividend ({1'b1, input_a[MAN_W-1:0]}),
    .divisor  ({1'b1, input_b[MAN_W-1:0]}),
    .quotient (quo),
    .sticky   (rem_nz),
    .last     (div_last)
  );

  assign {sign_a, exp_a, man_a} = op_a;
  assign {sign_b, exp_b, man_b} = op_b;
  assign sign_q = sign_a ^ sign_b;

  // Operand classes; a zero exponent (including subnormals) reads as zero
  assign zero_a = (exp_a == '0);
  assign zero_b = (exp_b == '0);
  assign inf_a  = (&exp_a) && (man_a == '0);
  assign inf_b  = (&exp_b) && (man_b == '0);
  assign nan_a  = (&exp_a) && (man_a != '0);
  assign nan_b  = (&exp_b) && (man_b != '0);

  assign inf_word  = {sign_q, {EXP_W{SPECIAL_EXP_BIT}}, {MAN_W{INF_MAN_BIT}}};
  assign zero_word = {sign_q, {(DATA_W-1){1'b0}}};
  assign qnan_word = {QNAN_SIGN, {EXP_W{SPECIAL_EXP_BIT}}, QNAN_MAN_MSB, {(MAN_W-1){1'b0}}};

  // Normalise the quotient, round to nearest even, and form the biased exponent
  always_comb begin
    norm_shift = ~quo[ITER-1];
    if (quo[ITER-1]) begin
      mant_n     = quo[ITER-1:2];
      guard      = quo[1];
      sticky_all = quo[0] | rem_nz;
    end else begin
      mant_n     = quo[ITER-2:1];
      guard      = quo[0];
      sticky_all = rem_nz;
    end
    round_up = guard & (sticky_all | mant_n[0]);
    mant_r   = {1'b0, mant_n} + {{(MAN_W+1){1'b0}}, round_up};
    carry    = mant_r[MAN_W+1];
    frac     = carry ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];
    e_raw    = {2'b00, exp_a} - {2'b00, exp_b} + BIAS
             - SE_W'(norm_shift) + SE_W'(carry);
    ovf      = ~e_raw[SE_W-1] && (e_raw >= EXP_MAX);
    unf      = e_raw[SE_W-1] || (e_raw == '0);
  end

  // Special operands take priority over the arithmetic result
  always_comb begin
    res_n = {sign_q, e_raw[EXP_W-1:0], frac};
    dbz_n = 1'b0;
    inv_n = 1'b0;
    if (nan_a || nan_b || (zero_a && zero_b) || (inf_a && inf_b)) begin
      res_n = qnan_word;
      inv_n = 1'b1;
    end else if (inf_a) begin
      res_n = inf_word;
    end else if (zero_b) begin
      res_n = inf_word;
      dbz_n = 1'b1;
    end else if (zero_a || inf_b) begin
      res_n = zero_word;
    end else if (ovf) begin
      res_n = inf_word;
    end else if (unf) begin
      res_n = zero_word;
    end
  end

endmodule

// File: doc/fp_divider_n.md
FP_DIVIDER_N -- requirements
Module: fp_divider_n

Interface
REQ-001 SHALL have parameter EXP_W, default 5, exponent field width.
REQ-002 SHALL have parameter MAN_W, default 10, stored mantissa width; DATA_W = 1+EXP_W+MAN_W (16 at defaults, IEEE binary16).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset_b  input  1  asynchronous, active-low reset.
REQ-005 input_a  input  DATA_W  dividend, sampled on accepted start.
REQ-006 input_b  input  DATA_W  divisor, sampled on accepted start.
REQ-007 start  input  1  request a division; accepted only when not busy.
REQ-008 clear  input  1  abort in-flight operation and drop valid.
REQ-009 busy  output  1  high while an operation is in flight.
REQ-010 valid  output  1  result holds a completed quotient; sticky.
REQ-011 result  output  DATA_W  quotient, held until next accepted start.
REQ-012 div_by_zero  output  1  finite nonzero / zero occurred; qualified by valid.
REQ-013 invalid  output  1  0/0, inf/inf or NaN operand; qualified by valid.

Function
REQ-014 SHALL implement FSM IDLE -> DIVIDE -> NORM -> DONE; DONE behaves as IDLE for start acceptance.
REQ-015 start in IDLE/DONE SHALL register operands, clear valid and flags next edge, enter DIVIDE; start in DIVIDE/NORM SHALL be ignored.
REQ-016 DIVIDE SHALL run restoring division on hidden-bit mantissas, one quotient bit per cycle, exactly MAN_W+3 cycles (quotient plus normalise and guard bits); sticky = remainder nonzero.
REQ-017 NORM SHALL, in one cycle, normalise (shift left 1, exponent-1 when quotient MSB is 0), round to nearest even, register result/flags, and set valid.
REQ-018 Latency SHALL be constant MAN_W+4 edges from the start-sampling edge to valid high (14 at defaults), for all operands including specials.
REQ-019 Exponent SHALL be computed in EXP_W+2-bit signed arithmetic: ea - eb + bias (bias = 2^(EXP_W-1)-1), minus normalisation, plus rounding carry.
REQ-020 Biased exponent >= all-ones SHALL return signed infinity; <= 0 SHALL return signed zero (flush, no subnormal output).
REQ-021 Subnormal inputs SHALL be treated as signed zero.
REQ-022 Sign SHALL be sign_a XOR sign_b except for NaN results.
REQ-023 Any NaN operand, 0/0 or inf/inf SHALL return canonical qNaN (sign 0, exponent all ones, mantissa MSB only) and set invalid.
REQ-024 Finite nonzero / zero SHALL return signed infinity and set div_by_zero; inf/finite SHALL return signed infinity; finite/inf and 0/nonzero SHALL return signed zero; no flags.
REQ-025 clear SHALL take effect next edge: FSM to IDLE, busy 0, valid 0; result and flags retain last values.
REQ-026 start and clear together in IDLE/DONE: start SHALL win; clear with start in DIVIDE/NORM: clear SHALL win (abort).
REQ-027 valid SHALL remain high until clear or next accepted start.

Reset
REQ-028 Reset SHALL force FSM IDLE, busy 0, valid 0, result 0, div_by_zero 0, invalid 0, iteration counter and datapath registers 0.
REQ-029 Reset asserted mid-operation SHALL abandon the operation; no valid pulse after release.

Structure
REQ-030 Package fp_div_pkg SHALL hold FSM state encoding, default EXP_W/MAN_W, and canonical qNaN/infinity field constants.
REQ-031 Mantissa restoring-division iterator (shift/subtract/counter, remainder, sticky) SHALL be sub-module fp_mant_div; control flops SHALL use the existing dff cell.

Verification
REQ-032 0x4600 / 0x4000 (6/2) -> result 0x4200, valid high exactly 14 edges after start, flags 0.
REQ-033 0x3C00 / 0x4200 (1/3) -> result 0x3555 (RNE), flags 0.
REQ-034 0x3C00 / 0x0000 -> 0x7C00, div_by_zero 1; 0x0000 / 0x0000 -> 0x7E00, invalid 1.
REQ-035 0x7BFF / 0x3800 (65504/0.5) -> 0x7C00; 0x0400 / 0x7BFF -> 0x0000 (flush).
REQ-036 clear 5 cycles after start -> busy and valid 0 next edge, no valid later; start during busy ignored, original result unchanged.
REQ-037 reset_b low during DIVIDE -> all outputs 0 immediately; after release, new 0xC000 / 0x4000 -> 0xBC00.
